button_input_interface: RTL

- Memory-mapped input peripheral: the read-side counterpart of the LED output interface.
- Samples N push-buttons, synchronises and debounces them, and latches press events.
- Drives an active-low interrupt request into the interrupt encoder.
- The CPU reads levels/events over the 16-bit data bus, using the per-device enables produced by the I/O address decoder.

---
 rtl/button_input_interface_pkg.sv | 13 +
 rtl/button_input_interface_if.sv | 14 +
 rtl/button_input_interface_debounce_cell.sv | 55 +++++
 rtl/button_input_interface.sv | 86 ++++++++
 4 files changed

// File: rtl/button_input_interface_pkg.sv
// Shared constants for the button input peripheral: register offsets and bus width.
package button_input_interface_pkg;

    localparam int BUS_W = 16;

    typedef enum logic [1:0] {
        REG_LEVEL = 2'd0,
        REG_EVENT = 2'd1,
        REG_MASK  = 2'd2,
        REG_RSVD  = 2'd3
    } reg_sel_e;

endpackage

// File: rtl/button_input_interface_if.sv
// CPU-side register bus of the button peripheral (decoder-qualified strobes).
interface button_input_interface_if;
    import button_input_interface_pkg::*;

    logic [1:0]       sel;
    logic             rd_en;
    logic             wr_en;
    logic [BUS_W-1:0] wr_data;
    logic [BUS_W-1:0] rd_data;

    modport master (output sel, output rd_en, output wr_en, output wr_data, input rd_data);
    modport slave  (input sel, input rd_en, input wr_en, input wr_data, output rd_data);

endinterface

// File: rtl/button_input_interface_debounce_cell.sv
// One button: 2-flop synchroniser, stability counter, debounced level and press pulse.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The counter has seen the synced value differ for DEBOUNCE_CYCLES cycles in a row.
    assign accept = (sync_2 != stable) && (cnt == CNT_LAST);

    // Bring the asynchronous pin into the clk domain.
    // NOTE: sequential state uses <= so every flop samples pre-edge values, which is what makes the two stages a real chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level once the run is long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_2 == stable) begin
            cnt <= '0;
        end else if (accept) begin
            stable <= sync_2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign level = stable;
    // High during the cycle whose rising edge moves stable from 0 to 1.
    assign rise  = accept && sync_2;

endmodule

// File: rtl/button_input_interface.sv
// Memory-mapped button peripheral: debounced levels, latched press events, mask and IRQ.
module button_input_interface
    import button_input_interface_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_in,
    button_input_interface_if.slave  bus,
    output logic                     irq_n
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] mask;
    logic [N_BTN-1:0] ev_clr;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .pin   (btn_in[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    // Event bits cleared this cycle: a read of EVENT clears all, a write clears the 1 bits.
    // NOTE: every always_comb output gets a default first so no path can leave it holding a value (no latch).
    always_comb begin
        ev_clr = '0;
        if (bus.sel == REG_EVENT) begin
            if (bus.rd_en) begin
                ev_clr = '1;
            end else if (bus.wr_en) begin
                ev_clr = bus.wr_data[N_BTN-1:0];
            end
        end
    end

    // Latch press events; a new press on the clearing edge survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~ev_clr) | rise;
        end
    end

    // Interrupt mask, loaded by a write to the MASK offset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
        end else if (bus.wr_en && (bus.sel == REG_MASK)) begin
            mask <= bus.wr_data[N_BTN-1:0];
        end
    end

    // Registered active-low request: lags the event/mask registers by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_n <= 1'b1;
        end else begin
            irq_n <= ~|(pending & mask);
        end
    end

    // Read mux; returns pre-edge register contents, zero when not selected.
    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_en) begin
            case (reg_sel_e'(bus.sel))
                REG_LEVEL: bus.rd_data = BUS_W'(level);
                REG_EVENT: bus.rd_data = BUS_W'(pending);
                REG_MASK:  bus.rd_data = BUS_W'(mask);
                default:   bus.rd_data = '0;
            endcase
        end
    end

endmodule
